// File: rtl/test_pattern_generator.sv
// Synthetic video source: framed line/pixel words with valid/ready handshake,
// programmable horizontal/vertical blanking and four ROM-less test patterns.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for enable_i && framesync_i; mode latched on exit
// ACTIVE | presenting words of the current line, advancing on accept
// HBLANK | H_BLANK idle cycles between active lines
// VBLANK | V_BLANK*(H_ACTIVE+H_BLANK) idle cycles after the last line
module test_pattern_generator #(
    parameter int DATA_W     = 16,
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int H_BLANK    = 32,
    parameter int V_BLANK    = 4,
    parameter int CHECK_LOG2 = 4,
    parameter int CNT_W      = 12
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              framesync_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sof_o,
    output logic              eol_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int BAR_LEN  = H_ACTIVE / 8;
    localparam int VB_CYC   = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int BLK_MAX  = (VB_CYC > H_BLANK) ? VB_CYC : H_BLANK;
    localparam int BLK_W    = $clog2(BLK_MAX + 1);
    localparam int BAR_W    = $clog2(BAR_LEN + 1);
    localparam int SUM_W    = (DATA_W > CNT_W + 1) ? DATA_W : CNT_W + 1;
    localparam int FRM_W    = (DATA_W > 16) ? DATA_W : 16;
    localparam int VB_LOADI = (VB_CYC > 0) ? VB_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [BLK_W-1:0] HB_LOAD   = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0] VB_LOAD   = BLK_W'(VB_LOADI);
    localparam logic [BAR_W-1:0] BAR_LOAD  = BAR_W'(BAR_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [2:0]        bar_q, bar_d;
    logic [BAR_W-1:0]  bar_left_q, bar_left_d;
    logic [BLK_W-1:0]  blank_q, blank_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       fval_q, fval_d;
    logic [15:0]       frame_q, frame_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              load;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]       mode,
        input logic [CNT_W-1:0] p,
        input logic [CNT_W-1:0] l,
        input logic [2:0]       bar,
        input logic [15:0]      fval
    );
        logic [SUM_W-1:0] sum;
        logic [FRM_W-1:0] fext;
        sum  = SUM_W'(p) + SUM_W'(l);
        fext = FRM_W'(fval);
        case (mode)
            2'd0:    pattern = sum[DATA_W-1:0];
            2'd1:    pattern = DATA_W'(bar) << (DATA_W - 3);
            2'd2:    pattern = (p[CHECK_LOG2] ^ l[CHECK_LOG2]) ? '1 : '0;
            default: pattern = fext[DATA_W-1:0];
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            line_q     <= '0;
            bar_q      <= '0;
            bar_left_q <= '0;
            blank_q    <= '0;
            mode_q     <= '0;
            fval_q     <= '0;
            frame_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            bar_q      <= bar_d;
            bar_left_q <= bar_left_d;
            blank_q    <= blank_d;
            mode_q     <= mode_d;
            fval_q     <= fval_d;
            frame_q    <= frame_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
        end
    end

    // Next-state logic; any branch that sets `load` registers the word for
    // the (pix_d, line_d) position so it appears on the following cycle.
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        line_d     = line_q;
        bar_d      = bar_q;
        bar_left_d = bar_left_q;
        blank_d    = blank_q;
        mode_d     = mode_q;
        fval_d     = fval_q;
        frame_d    = frame_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i && framesync_i) begin
                    state_d    = ACTIVE;
                    mode_d     = mode_i;
                    fval_d     = frame_q;
                    pix_d      = '0;
                    line_d     = '0;
                    bar_d      = '0;
                    bar_left_d = BAR_LOAD;
                    sof_d      = 1'b1;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (valid_q && ready_i) begin
                    sof_d = 1'b0;
                    if (pix_q == PIX_LAST) begin
                        valid_d = 1'b0;
                        eol_d   = 1'b0;
                        if (line_q == LINE_LAST) begin
                            if (VB_CYC == 0) begin
                                state_d = IDLE;
                                frame_d = frame_q + 16'd1;
                            end else begin
                                state_d = VBLANK;
                                blank_d = VB_LOAD;
                            end
                        end else begin
                            state_d = HBLANK;
                            blank_d = HB_LOAD;
                        end
                    end else begin
                        pix_d = pix_q + 1'b1;
                        load  = 1'b1;
                        if (bar_left_q == '0) begin
                            bar_d      = bar_q + 3'd1;
                            bar_left_d = BAR_LOAD;
                        end else begin
                            bar_left_d = bar_left_q - 1'b1;
                        end
                    end
                end
            end
            HBLANK: begin
                if (blank_q == '0) begin
                    state_d    = ACTIVE;
                    line_d     = line_q + 1'b1;
                    pix_d      = '0;
                    bar_d      = '0;
                    bar_left_d = BAR_LOAD;
                    load       = 1'b1;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
            VBLANK: begin
                if (blank_q == '0) begin
                    state_d = IDLE;
                    frame_d = frame_q + 16'd1;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
        endcase

        if (load) begin
            data_d  = pattern(mode_d, pix_d, line_d, bar_d, fval_d);
            valid_d = 1'b1;
            eol_d   = (pix_d == PIX_LAST);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_test_pattern_generator.sv
// Bench for test_pattern_generator: directed lifecycle scenarios plus random
// handshake/mode/framesync traffic checked against a frame-level reference model.
module tb_test_pattern_generator;
    localparam int DATA_W     = 16;
    localparam int H_ACTIVE   = 16;
    localparam int V_ACTIVE   = 4;
    localparam int H_BLANK    = 3;
    localparam int V_BLANK    = 2;
    localparam int CHECK_LOG2 = 1;
    localparam int CNT_W      = 12;
    localparam int VB_CYC     = V_BLANK * (H_ACTIVE + H_BLANK);

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic              framesync_i;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              sof_o;
    logic              eol_o;
    logic [15:0]       frame_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        last;
    } word_t;

    // Reference model: the whole frame's expected words are built at frame
    // start; timing is tracked as "cycles of silence still owed".
    word_t       exp_q[$];
    bit          m_busy;
    int          m_gap;
    bit          m_end;
    logic [15:0] m_fc;

    always #5 clk_i = ~clk_i;

    test_pattern_generator #(
        .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .CHECK_LOG2(CHECK_LOG2), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .framesync_i(framesync_i),
        .mode_i(mode_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .sof_o(sof_o),
        .eol_o(eol_o),
        .frame_cnt_o(frame_cnt_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [1:0] mode, input logic [15:0] fc);
        word_t w;
        exp_q.delete();
        for (int l = 0; l < V_ACTIVE; l++) begin
            for (int p = 0; p < H_ACTIVE; p++) begin
                case (mode)
                    2'd0:    w.data = 16'(p + l);
                    2'd1:    w.data = 16'((p / (H_ACTIVE / 8)) << (DATA_W - 3));
                    2'd2:    w.data = ((((p >> CHECK_LOG2) ^ (l >> CHECK_LOG2)) & 1) != 0) ? 16'hFFFF : 16'h0000;
                    default: w.data = fc;
                endcase
                w.sof  = (p == 0) && (l == 0);
                w.eol  = (p == H_ACTIVE - 1);
                w.last = w.eol && (l == V_ACTIVE - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic step();
        bit          en, fs, rdy, exp_valid;
        logic [1:0]  md;
        word_t       w;
        en  = enable_i;
        fs  = framesync_i;
        rdy = ready_i;
        md  = mode_i;
        @(posedge clk_i);
        #1;
        if (!m_busy) begin
            if (en && fs) begin
                build_frame(md, m_fc);
                m_busy = 1'b1;
                m_gap  = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && m_end) begin
                m_busy = 1'b0;
                m_fc   = m_fc + 16'd1;
            end
        end else if (rdy && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            if (w.eol) begin
                m_end = w.last;
                m_gap = w.last ? VB_CYC : H_BLANK;
            end
        end
        exp_valid = m_busy && (m_gap == 0);
        check_val("valid", 32'(valid_o), 32'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            check_val("data", 32'(data_o), 32'(exp_q[0].data));
            check_val("sof", 32'(sof_o), 32'(exp_q[0].sof));
            check_val("eol", 32'(eol_o), 32'(exp_q[0].eol));
        end else begin
            check_val("sof_eol_idle", 32'({sof_o, eol_o}), 32'd0);
        end
        check_val("frame_cnt", 32'(frame_cnt_o), 32'(m_fc));
    endtask

    task automatic wait_idle(input bit rand_rdy);
        int k = 0;
        while (m_busy && k < 400) begin
            if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        check_val("idle_reached", 32'(m_busy), 32'd0);
        ready_i = 1'b1;
    endtask

    task automatic do_reset_async();
        #3 reset_i = 1'b1;
        #1;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check_val("rst_data", 32'(data_o), 32'd0);
        check_val("rst_sof_eol", 32'({sof_o, eol_o}), 32'd0);
        exp_q.delete();
        m_busy = 1'b0;
        m_gap  = 0;
        m_end  = 1'b0;
        m_fc   = 16'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] md);
        mode_i      = md;
        framesync_i = 1'b1;
        step();
        framesync_i = 1'b0;
    endtask

    initial begin
        reset_i     = 1'b0;
        enable_i    = 1'b0;
        framesync_i = 1'b0;
        ready_i     = 1'b1;
        mode_i      = 2'd0;
        m_busy      = 1'b0;
        m_gap       = 0;
        m_end       = 1'b0;
        m_fc        = 16'd0;
        do_reset_async();

        // Mode 0, always ready: one full frame including VBLANK.
        enable_i = 1'b1;
        start_frame(2'd0);
        check_val("t1_first_sof", 32'(sof_o), 32'd1);
        check_val("t1_first_data", 32'(data_o), 32'd0);
        repeat (130) step();
        check_val("t1_frame_cnt", 32'(frame_cnt_o), 32'd1);

        // Backpressure held on word 5.
        start_frame(2'd0);
        for (int k = 0; k < 30 && !(valid_o && data_o == 16'd5); k++) step();
        check_val("bp_reach5", 32'(data_o), 32'd5);
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("bp_hold_data", 32'(data_o), 32'd5);
            check_val("bp_hold_valid", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1;
        step();
        check_val("bp_next", 32'(data_o), 32'd6);
        wait_idle(1'b0);

        // Colour bars with random backpressure.
        start_frame(2'd1);
        wait_idle(1'b1);

        // Checkerboard; mode_i flips to ramp mid-frame.
        start_frame(2'd2);
        repeat (10) step();
        mode_i = 2'd0;
        wait_idle(1'b1);

        // Frame counter pattern from a clean reset, framesync pulsed mid-frame.
        do_reset_async();
        for (int f = 0; f < 3; f++) begin
            start_frame(2'd3);
            for (int k = 0; k < 130; k++) begin
                framesync_i = (k == 10 || k == 40);
                step();
            end
            framesync_i = 1'b0;
            wait_idle(1'b0);
        end
        check_val("t5_frame_cnt", 32'(frame_cnt_o), 32'd3);

        // enable_i dropped during line 1: frame completes, no restart.
        start_frame(2'd0);
        repeat (24) step();
        enable_i    = 1'b0;
        framesync_i = 1'b1;
        repeat (200) step();
        check_val("t6_stays_idle", 32'(valid_o), 32'd0);
        check_val("t6_frame_cnt", 32'(frame_cnt_o), 32'd4);
        framesync_i = 1'b0;
        enable_i    = 1'b1;

        // Reset mid-line, then a fresh frame from pixel 0.
        start_frame(2'd0);
        repeat (8) step();
        do_reset_async();
        start_frame(2'd0);
        check_val("t6_restart_sof", 32'(sof_o), 32'd1);
        check_val("t6_restart_data", 32'(data_o), 32'd0);
        wait_idle(1'b0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            framesync_i = ($urandom_range(0, 7) == 0);
            ready_i     = ($urandom_range(0, 3) != 0);
            mode_i      = 2'($urandom_range(0, 3));
            enable_i    = ($urandom_range(0, 15) != 0);
            step();
        end
        framesync_i = 1'b0;
        wait_idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
